// File: rtl/sm_step_ctrl.sv
// Debug run controller: issues one-cycle cpuEn ticks for run/halt/N-step with a PC breakpoint.
// Optional cycleCount counter is built when SM_STEP_CTRL_CYCLE_CNT_EN is defined.
module sm_step_ctrl #(
  parameter int DIV_W  = 16,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        devide,
  input  logic              cmdValid,
  input  logic [1:0]        cmd,
  input  logic [STEP_W-1:0] stepCount,
  input  logic [31:0]       pc,
  input  logic              bpEnable,
  input  logic [31:0]       bpAddr,
  output logic              cpuEn,
  output logic              cmdAck,
  output logic [1:0]        state,
  output logic              halted,
  output logic [31:0]       cycleCount
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_RUN  = 2'd1,
    CMD_HALT = 2'd2,
    CMD_STEP = 2'd3
  } cmd_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [STEP_W-1:0]   remaining_q, remaining_d;
  logic                skip_bp_q, skip_bp_d;
  logic                cpu_en_q, cpu_en_d;
  logic                cmd_ack_q, cmd_ack_d;

  logic [DIV_W-1:0]    period_m1;
  logic [DIV_W-1:0]    div_adv;
  logic [STEP_W-1:0]   step_load;
  logic                active_q;
  logic                tick_ok;
  cmd_e                cmd_in;

  assign period_m1 = (DIV_W'(1) << devide) - DIV_W'(1);
  assign div_adv   = (div_cnt_q == period_m1) ? '0 : div_cnt_q + DIV_W'(1);
  assign step_load = (stepCount == '0) ? STEP_W'(1) : stepCount;
  assign active_q  = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign cmd_in    = cmd_e'(cmd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HALT;
      div_cnt_q   <= '0;
      remaining_q <= '0;
      skip_bp_q   <= 1'b0;
      cpu_en_q    <= 1'b0;
      cmd_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      remaining_q <= remaining_d;
      skip_bp_q   <= skip_bp_d;
      cpu_en_q    <= cpu_en_d;
      cmd_ack_q   <= cmd_ack_d;
    end
  end

  // The tick is judged on the post-command counter value so that a (re)start with
  // P=1 can already produce the pulse registered at the end of the accept cycle.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    remaining_d = remaining_q;
    skip_bp_d   = skip_bp_q;
    cpu_en_d    = 1'b0;
    cmd_ack_d   = cmdValid;
    tick_ok     = 1'b0;

    if (cmdValid) begin
      unique case (cmd_in)
        CMD_RUN: begin
          if (state_q != ST_RUN) begin
            state_d   = ST_RUN;
            div_cnt_d = '0;
            tick_ok   = 1'b1;
            skip_bp_d = skip_bp_q | (state_q == ST_BREAK);
          end else begin
            div_cnt_d = div_adv;
          end
        end
        CMD_STEP: begin
          state_d     = ST_STEP;
          remaining_d = step_load;
          div_cnt_d   = '0;
          tick_ok     = 1'b1;
          skip_bp_d   = skip_bp_q | (state_q == ST_BREAK);
        end
        CMD_HALT: begin
          state_d = ST_HALT;
          if (state_q == ST_STEP) remaining_d = '0;
          if (state_q == ST_BREAK) skip_bp_d = 1'b0;
        end
        default: begin
          if (active_q) div_cnt_d = div_adv;
        end
      endcase
    end else if (active_q) begin
      div_cnt_d = div_adv;
      tick_ok   = 1'b1;
    end

    if (tick_ok && (state_d == ST_RUN || state_d == ST_STEP) && div_cnt_d == period_m1) begin
      if (bpEnable && pc == bpAddr && !skip_bp_d) begin
        state_d = ST_BREAK;
      end else begin
        cpu_en_d  = 1'b1;
        skip_bp_d = 1'b0;
        if (state_d == ST_STEP) begin
          if (remaining_d == STEP_W'(1)) state_d = ST_HALT;
          remaining_d = remaining_d - STEP_W'(1);
        end
      end
    end
  end

  always_comb begin
    cpuEn  = cpu_en_q;
    cmdAck = cmd_ack_q;
    state  = state_q;
    halted = (state_q == ST_HALT) || (state_q == ST_BREAK);
  end

`ifdef SM_STEP_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (cpu_en_d) cycle_cnt_d = cycle_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_cnt_q <= '0;
    else     cycle_cnt_q <= cycle_cnt_d;
  end

  assign cycleCount = cycle_cnt_q;
`else
  assign cycleCount = '0;
`endif

endmodule

// File: tb/tb_sm_step_ctrl.sv
// Scoreboard bench for sm_step_ctrl: an absolute-time tick schedule model predicts each cycle's outputs.
module tb_sm_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  devide = 4'd0;
  logic        cmdValid = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic [15:0] stepCount = 16'd0;
  logic [31:0] pc = 32'd0;
  logic        bpEnable = 1'b0;
  logic [31:0] bpAddr = 32'd0;
  logic        cpuEn, cmdAck, halted;
  logic [1:0]  state;
  logic [31:0] cycleCount;

  sm_step_ctrl #(.DIV_W(16), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .devide(devide), .cmdValid(cmdValid), .cmd(cmd),
    .stepCount(stepCount), .pc(pc), .bpEnable(bpEnable), .bpAddr(bpAddr),
    .cpuEn(cpuEn), .cmdAck(cmdAck), .state(state), .halted(halted),
    .cycleCount(cycleCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic        en;
    logic        ack;
    logic [1:0]  st;
    logic [31:0] cc;
  } exp_t;

  exp_t sb[$];

  // Reference model: schedule expressed as the absolute cycle of the next pulse.
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_BRK = 3;
  int m_st   = M_HALT;
  int m_due  = 0;
  int m_rem  = 0;
  bit m_skip = 1'b0;
  int m_n    = 0;

  task automatic model_reset();
    m_st = M_HALT; m_due = 0; m_rem = 0; m_skip = 1'b0; m_n = 0;
  endtask

  task automatic step(input logic v, input logic [1:0] c, input logic [15:0] sc);
    exp_t e;
    int   t, p;
    bit   restarted, en;
    @(posedge clk); #1;
    t = cyc;
    cmdValid = v; cmd = c; stepCount = sc;
    pc = 32'(4 * m_n);
    p = 1 << devide;
    restarted = 1'b0;
    en = 1'b0;
    if (v) begin
      case (c)
        2'd1: if (m_st != M_RUN) begin
                if (m_st == M_BRK) m_skip = 1'b1;
                m_st = M_RUN; m_due = t + p; restarted = 1'b1;
              end
        2'd3: begin
                if (m_st == M_BRK) m_skip = 1'b1;
                m_st = M_STEP; m_rem = (sc == 0) ? 1 : int'(sc);
                m_due = t + p; restarted = 1'b1;
              end
        2'd2: begin
                if (m_st == M_STEP) m_rem = 0;
                if (m_st == M_BRK) m_skip = 1'b0;
                m_st = M_HALT;
              end
        default: ;
      endcase
    end
    if ((m_st == M_RUN || m_st == M_STEP) && m_due == t + 1) begin
      m_due += p;
      if (!v || restarted) begin
        if (bpEnable && pc == bpAddr && !m_skip) m_st = M_BRK;
        else begin
          en = 1'b1; m_skip = 1'b0; m_n++;
          if (m_st == M_STEP) begin
            m_rem--;
            if (m_rem == 0) m_st = M_HALT;
          end
        end
      end
    end
    e.cyc = t + 1; e.en = en; e.ack = v; e.st = 2'(m_st);
`ifdef SM_STEP_CTRL_CYCLE_CNT_EN
    e.cc = 32'(m_n);
`else
    e.cc = 32'd0;
`endif
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 16'd0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("cpuEn", 32'(cpuEn), 32'(e.en));
      chk("cmdAck", 32'(cmdAck), 32'(e.ack));
      chk("state", 32'(state), 32'(e.st));
      chk("halted", 32'(halted), 32'(e.st == 2'd0 || e.st == 2'd3));
      chk("cycleCount", cycleCount, e.cc);
    end
  end

  task automatic async_reset_check();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_cpuEn", 32'(cpuEn), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_cmdAck", 32'(cmdAck), 32'd0);
    chk("rst_cycleCount", cycleCount, 32'd0);
    sb.delete();
    model_reset();
    cmdValid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("init_cpuEn", 32'(cpuEn), 32'd0);
    chk("init_state", 32'(state), 32'd0);
    chk("init_halted", 32'(halted), 32'd1);
    chk("init_cycleCount", cycleCount, 32'd0);

    // RUN at P=1, then halt
    devide = 4'd0;
    idle(6);
    step(1'b1, 2'd1, 16'd0);
    idle(8);
    step(1'b1, 2'd2, 16'd0);
    idle(3);

    // STEP 3 at P=4
    devide = 4'd2;
    step(1'b1, 2'd3, 16'd3);
    idle(16);

    // STEP with count 0 behaves as 1
    step(1'b1, 2'd3, 16'd0);
    idle(6);

    // breakpoint at 0x20, pc advances 4 per pulse from 0, then resume by single step
    async_reset_check();
    devide = 4'd0; bpEnable = 1'b1; bpAddr = 32'h20;
    step(1'b1, 2'd1, 16'd0);
    idle(14);
    step(1'b1, 2'd3, 16'd1);
    idle(5);
    bpEnable = 1'b0;

    // HALT landing exactly on a tick at P=8
    devide = 4'd3;
    step(1'b1, 2'd1, 16'd0);
    idle(10);
    guard = 0;
    while (m_due != cyc + 2 && guard < 20) begin
      idle(1);
      guard++;
    end
    chk("tick_align_bound", 32'(m_due == cyc + 2), 32'd1);
    step(1'b1, 2'd2, 16'd0);
    idle(12);

    // asynchronous reset in the middle of a 5-step
    devide = 4'd1;
    step(1'b1, 2'd3, 16'd5);
    idle(1);
    async_reset_check();
    idle(8);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic v;
      logic [1:0] c;
      if (m_st == M_HALT || m_st == M_BRK) begin
        if ($urandom_range(0, 3) == 0) devide = 4'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) begin
          bpEnable = 1'($urandom_range(0, 1));
          bpAddr   = 32'(4 * $urandom_range(0, 60));
        end
      end
      v = ($urandom_range(0, 6) == 0);
      c = 2'($urandom_range(0, 3));
      step(v, c, 16'($urandom_range(0, 4)));
    end
    idle(3);
    @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sm_step_ctrl.md
Name: sm_step_ctrl

Overview:
- Debug run controller that sequences the CPU clock.
- Generates a one-cycle cpuEn strobe at a programmable rate.
- Supports run, halt, single/N-step and a PC breakpoint.
- Sits between the board-level debug inputs and the CPU clock-enable path, replacing the free-running divided clock with controlled ticks.

Parameters:
- DIV_W, 16: width of the tick period counter. Maximum period is 2^(DIV_W-1) cycles.
- STEP_W, 16: width of the step count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- devide  in  4  tick period select. Period P = 2^devide clk cycles. devide must be at most DIV_W-1.
- cmdValid  in  1  command strobe, one cycle.
- cmd  in  2  command: 0 NOP, 1 RUN, 2 HALT, 3 STEP.
- stepCount  in  STEP_W  number of ticks for STEP. 0 is treated as 1.
- pc  in  32  current CPU instruction address (imAddr).
- bpEnable  in  1  breakpoint enable.
- bpAddr  in  32  breakpoint address.
- cpuEn  out  1  CPU tick strobe, one cycle.
- cmdAck  out  1  pulses the cycle after any accepted command, NOP included.
- state  out  2  0 HALT, 1 RUN, 2 STEP, 3 BREAK.
- halted  out  1  high in HALT or BREAK.
- cycleCount  out  32  number of cpuEn pulses issued (optional feature).

Behaviour:
- Reset (asynchronous): state=HALT, cpuEn=0, cmdAck=0, halted=1, cycleCount=0, divCnt=0, remaining=0, skipBp=0.
- Commands are always accepted. cmdAck is registered: high exactly one cycle after cmdValid.
- divCnt runs only in RUN/STEP. It is cleared on every transition into RUN or STEP.
- Tick fires when divCnt==P-1; divCnt then wraps to 0.
- First cpuEn after accepting RUN/STEP occurs exactly P cycles after the accept cycle. With P=1, a tick fires every cycle starting one cycle after accept.
- cpuEn is registered: high the cycle after the tick condition.
- Breakpoint hit: in the tick cycle, if bpEnable && pc==bpAddr && !skipBp, no cpuEn is issued. State goes to BREAK; remaining is kept.
- skipBp is set on any RUN/STEP accepted while in BREAK. It is cleared when the next cpuEn is issued, so resume is always possible from the breakpoint PC.
- HALT: on RUN, go to RUN. On STEP, load remaining=max(stepCount,1) and go to STEP. HALT and NOP have no effect.
- RUN: cpuEn on every non-breakpoint tick. On HALT, go to HALT. On STEP, load remaining and go to STEP, clearing divCnt.
- STEP: each issued cpuEn decrements remaining. When the cpuEn with remaining==1 issues, go to HALT.
  - HALT command: go to HALT, remaining=0.
  - RUN command: go to RUN.
  - STEP command: reload remaining and clear divCnt.
- BREAK: holds until RUN or STEP (handled as from HALT, with skipBp=1). HALT command moves BREAK to HALT and clears skipBp.
- Command and tick in the same cycle: the command wins. That tick issues no cpuEn and does not decrement remaining.
- devide changing mid-run takes effect at the next tick compare. If divCnt already exceeds the new P-1, the count runs to the DIV_W wrap before ticking again. Software is required to halt before changing devide.
- remaining, divCnt and cycleCount wrap modulo their widths. There is no saturation.

Optional Feature:
- Macro: SM_STEP_CTRL_CYCLE_CNT_EN.
- Defined: 32-bit cycleCount increments on every cpuEn, cleared only by rst, and wraps at 2^32.
- Undefined: no counter logic is built; cycleCount is tied to 0.

Test Plan:
- Reset, devide=0, cmd RUN at cycle 10 -> cpuEn first high at cycle 11, then every cycle. state=1, halted=0, cmdAck high at cycle 11.
- devide=2, cmd STEP with stepCount=3 -> exactly 3 cpuEn pulses spaced 4 cycles apart, the first 4 cycles after accept. Then state=0 and halted=1. cycleCount=3 when the macro is defined.
- STEP with stepCount=0 -> exactly 1 cpuEn, then HALT.
- RUN, devide=0, bpEnable=1, bpAddr=0x20, pc stepping by 4 per cpuEn from 0 -> cpuEn suppressed when pc=0x20, state=3. A subsequent STEP with stepCount=1 -> one cpuEn despite pc=0x20, then HALT.
- RUN with devide=3, then cmd HALT issued in a tick cycle -> no cpuEn that cycle, state=0 next cycle, no further pulses.
- Assert rst mid-STEP (remaining=5) -> outputs return to reset values immediately, asynchronously. No cpuEn after release until a new command is accepted.
